// File: rtl/arb_pkg.sv
// Shared types for the two-into-one physical bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, RESP, HOLD} arb_state_e;
  typedef enum logic {IF = 1'b0, MA = 1'b1} arb_owner_e;

  localparam int TL_AW = 32;
  localparam int TL_DW = 32;

  function automatic arb_owner_e flip_owner(input arb_owner_e o);
    return (o == IF) ? MA : IF;
  endfunction

endpackage

// File: rtl/tilelink.sv
// TileLink-UL style channel bundle (A request, D response) with master/slave views.
interface tilelink;

  logic                            a_valid;
  logic                            a_ready;
  logic [2:0]                      a_opcode;
  logic [arb_pkg::TL_AW-1:0]       a_address;
  logic [arb_pkg::TL_DW-1:0]       a_data;
  logic [arb_pkg::TL_DW/8-1:0]     a_mask;
  logic                            d_valid;
  logic                            d_ready;
  logic [2:0]                      d_opcode;
  logic [arb_pkg::TL_DW-1:0]       d_data;
  logic                            d_error;

  modport master (
    output a_valid, a_opcode, a_address, a_data, a_mask, d_ready,
    input  a_ready, d_valid, d_opcode, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_address, a_data, a_mask, d_ready,
    output a_ready, d_valid, d_opcode, d_data, d_error
  );

endinterface

// File: rtl/phy_arbiter.sv
// Round-robin arbiter merging fetch and memory-access buses onto one system bus,
// one transaction outstanding, with an optional request-driven bus lock.
module phy_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    if_request,
  tilelink.slave  if_bus,
  input  logic    ma_request,
  tilelink.slave  ma_bus,
  tilelink.master mem_bus,
  output logic    grant_if,
  output logic    grant_ma
);

  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

  arb_state_e       state_reg;
  arb_owner_e       owner_reg;
  arb_owner_e       last_reg;
  logic [CNT_W-1:0] hold_cnt_reg;

  logic own_a_valid;
  logic own_d_ready;
  logic own_request;
  logic own_is_ma;
  logic a_fire;
  logic d_fire;
  logic hold_ok;

  assign own_is_ma   = (owner_reg == MA);
  assign own_a_valid = own_is_ma ? ma_bus.a_valid : if_bus.a_valid;
  assign own_d_ready = own_is_ma ? ma_bus.d_ready : if_bus.d_ready;
  assign own_request = own_is_ma ? ma_request     : if_request;
  assign a_fire      = (state_reg == ADDR) && own_a_valid && mem_bus.a_ready;
  assign d_fire      = (state_reg == RESP) && mem_bus.d_valid && own_d_ready;
  assign hold_ok     = (HOLD_MAX == 0) || ((32'(hold_cnt_reg) + 32'd1) < 32'(HOLD_MAX));

  assign grant_if = (state_reg != IDLE) && !own_is_ma;
  assign grant_ma = (state_reg != IDLE) &&  own_is_ma;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= IF;
      last_reg     <= IF;
      hold_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          hold_cnt_reg <= '0;
          // On a tie the side that did not finish last wins.
          if (if_bus.a_valid && ma_bus.a_valid) begin
            owner_reg <= flip_owner(last_reg);
            state_reg <= ADDR;
          end else if (if_bus.a_valid) begin
            owner_reg <= IF;
            state_reg <= ADDR;
          end else if (ma_bus.a_valid) begin
            owner_reg <= MA;
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          if (a_fire) state_reg <= RESP;
        end
        RESP: begin
          if (d_fire) begin
            last_reg <= owner_reg;
            if (hold_cnt_reg != CNT_W'(HOLD_MAX)) hold_cnt_reg <= hold_cnt_reg + 1'b1;
            state_reg <= (own_request && hold_ok) ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (own_a_valid)       state_reg <= ADDR;
          else if (!own_request) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Payload follows the owner register; handshakes are gated by state so the
  // non-owner and idle phases never see ready/valid.
  always_comb begin
    mem_bus.a_valid   = (state_reg == ADDR) && own_a_valid;
    mem_bus.a_opcode  = own_is_ma ? ma_bus.a_opcode  : if_bus.a_opcode;
    mem_bus.a_address = own_is_ma ? ma_bus.a_address : if_bus.a_address;
    mem_bus.a_data    = own_is_ma ? ma_bus.a_data    : if_bus.a_data;
    mem_bus.a_mask    = own_is_ma ? ma_bus.a_mask    : if_bus.a_mask;
    mem_bus.d_ready   = (state_reg == RESP) && own_d_ready;

    if_bus.a_ready    = (state_reg == ADDR) && !own_is_ma && mem_bus.a_ready;
    ma_bus.a_ready    = (state_reg == ADDR) &&  own_is_ma && mem_bus.a_ready;
    if_bus.d_valid    = (state_reg == RESP) && !own_is_ma && mem_bus.d_valid;
    ma_bus.d_valid    = (state_reg == RESP) &&  own_is_ma && mem_bus.d_valid;

    if_bus.d_opcode   = mem_bus.d_opcode;
    if_bus.d_data     = mem_bus.d_data;
    if_bus.d_error    = mem_bus.d_error;
    ma_bus.d_opcode   = mem_bus.d_opcode;
    ma_bus.d_data     = mem_bus.d_data;
    ma_bus.d_error    = mem_bus.d_error;
  end

endmodule

// File: tb/tb_phy_arbiter.sv
// Directed bench: cycle vector table on the unlimited-lock arbiter, then a
// page-walk sequence run side by side on HOLD_MAX=0 and HOLD_MAX=2 instances.
module tb_phy_arbiter;
  import arb_pkg::*;

  localparam logic [31:0] IF_ADDR = 32'h8000_0000;
  localparam logic [31:0] MA_ADDR = 32'h1000_0040;
  localparam logic [31:0] WALK_BASE = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0] if_req, ma_req, if_av, ma_av, if_dr, ma_dr, m_ar, m_dv;
  logic [31:0] if_addr [2];
  logic [31:0] ma_addr [2];
  logic [31:0] m_ddata [2];
  logic [1:0] g_if, g_ma, m_av, m_dr, if_ar, ma_ar, if_dv, ma_dv;
  logic [31:0] m_addr [2];

  int tests = 0;
  int fails = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    tilelink if_bus ();
    tilelink ma_bus ();
    tilelink mem_bus ();

    assign if_bus.a_valid   = if_av[gi];
    assign if_bus.a_opcode  = 3'd4;
    assign if_bus.a_address = if_addr[gi];
    assign if_bus.a_data    = '0;
    assign if_bus.a_mask    = 4'hF;
    assign if_bus.d_ready   = if_dr[gi];

    assign ma_bus.a_valid   = ma_av[gi];
    assign ma_bus.a_opcode  = 3'd4;
    assign ma_bus.a_address = ma_addr[gi];
    assign ma_bus.a_data    = '0;
    assign ma_bus.a_mask    = 4'hF;
    assign ma_bus.d_ready   = ma_dr[gi];

    assign mem_bus.a_ready  = m_ar[gi];
    assign mem_bus.d_valid  = m_dv[gi];
    assign mem_bus.d_opcode = 3'd1;
    assign mem_bus.d_data   = m_ddata[gi];
    assign mem_bus.d_error  = 1'b0;

    assign m_av[gi]   = mem_bus.a_valid;
    assign m_dr[gi]   = mem_bus.d_ready;
    assign m_addr[gi] = mem_bus.a_address;
    assign if_ar[gi]  = if_bus.a_ready;
    assign ma_ar[gi]  = ma_bus.a_ready;
    assign if_dv[gi]  = if_bus.d_valid;
    assign ma_dv[gi]  = ma_bus.d_valid;

    phy_arbiter #(.HOLD_MAX(gi == 0 ? 0 : 2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_request (if_req[gi]),
      .if_bus     (if_bus),
      .ma_request (ma_req[gi]),
      .ma_bus     (ma_bus),
      .mem_bus    (mem_bus),
      .grant_if   (g_if[gi]),
      .grant_ma   (g_ma[gi])
    );
  end

  // in  = {rst_n, if_req, if_av, ma_req, ma_av, m_ar, m_dv, if_dr, ma_dr}
  // exp = {g_if, g_ma, m_av, m_dr, if_ar, ma_ar, if_dv, ma_dv}
  typedef struct {
    string       name;
    logic [8:0]  in;
    logic [7:0]  exp;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [8:0] in, input logic [7:0] exp,
                     input logic [31:0] exp_addr);
    vec_t v;
    v.name = name; v.in = in; v.exp = exp; v.exp_addr = exp_addr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, got);
    end
  endtask

  task automatic zero_inputs();
    if_req = '0; ma_req = '0; if_av = '0; ma_av = '0;
    if_dr = '0; ma_dr = '0; m_ar = '0; m_dv = '0;
    for (int k = 0; k < 2; k++) begin
      if_addr[k] = IF_ADDR;
      ma_addr[k] = MA_ADDR;
      m_ddata[k] = 32'hCAFE_0001;
    end
  endtask

  int          ma_left [2];
  int          if_left [2];
  logic        ma_busy [2];
  logic        if_busy [2];
  logic        pend    [2];
  int          nbeat   [2];
  logic        beat_ma   [2][8];
  logic [31:0] beat_addr [2][8];
  logic        exp_ma    [2][4];
  logic [31:0] exp_baddr [2][4];

  initial begin
    logic [7:0] got;
    logic       done;

    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);

    add("reset_idle",     9'b0_0_1_0_1_0_0_0_0, 8'b0000_0000, '0);
    add("tie_idle",       9'b1_0_1_0_1_1_0_0_0, 8'b0000_0000, '0);
    add("tie_ma_addr",    9'b1_0_1_0_1_1_0_0_0, 8'b0110_0100, MA_ADDR);
    add("tie_ma_resp",    9'b1_0_1_0_0_1_1_1_1, 8'b0101_0001, '0);
    add("if_c0_idle",     9'b1_0_1_0_0_1_0_1_1, 8'b0000_0000, '0);
    add("if_c1_wait",     9'b1_0_1_0_0_0_0_1_1, 8'b1010_0000, IF_ADDR);
    add("if_c2_wait",     9'b1_0_1_0_0_0_0_1_1, 8'b1010_0000, IF_ADDR);
    add("if_c3_wait",     9'b1_0_1_0_0_0_0_1_1, 8'b1010_0000, IF_ADDR);
    add("if_c4_fire_dv",  9'b1_0_1_0_0_1_1_1_1, 8'b1010_1000, IF_ADDR);
    for (int s = 0; s < 5; s++)
      add($sformatf("dstall_%0d", s), 9'b1_0_0_0_1_1_1_0_1, 8'b1000_0010, '0);
    add("dstall_release", 9'b1_0_0_0_1_1_1_1_1, 8'b1001_0010, '0);
    add("ma_idle",        9'b1_0_0_0_1_1_0_1_1, 8'b0000_0000, '0);
    add("ma_addr",        9'b1_0_0_0_1_1_0_1_1, 8'b0110_0100, MA_ADDR);
    add("ma_resp_wait",   9'b1_0_0_0_0_1_0_1_1, 8'b0101_0000, '0);
    add("rst_in_resp",    9'b0_0_0_0_0_1_1_1_1, 8'b0101_0001, '0);
    add("post_rst_0",     9'b1_0_0_0_0_1_1_1_1, 8'b0000_0000, '0);
    add("post_rst_stray", 9'b1_0_0_0_0_1_1_1_1, 8'b0000_0000, '0);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      {rst_n, if_req[0], if_av[0], ma_req[0], ma_av[0], m_ar[0], m_dv[0], if_dr[0], ma_dr[0]} = vecs[i].in;
      #1;
      got = {g_if[0], g_ma[0], m_av[0], m_dr[0], if_ar[0], ma_ar[0], if_dv[0], ma_dv[0]};
      check(vecs[i].name, 64'(got), 64'(vecs[i].exp));
      if (vecs[i].exp[5]) check({vecs[i].name, "_addr"}, 64'(m_addr[0]), 64'(vecs[i].exp_addr));
    end

    // Page walk: MA locks for three reads while IF keeps a fetch pending.
    @(posedge clk); #1;
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ma_left[k] = 3; if_left[k] = 1; ma_busy[k] = 1'b0; if_busy[k] = 1'b0;
      pend[k] = 1'b0; nbeat[k] = 0;
    end
    exp_ma[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_baddr[0] = '{WALK_BASE, WALK_BASE + 32'h8, WALK_BASE + 32'h10, IF_ADDR};
    exp_ma[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_baddr[1] = '{WALK_BASE, WALK_BASE + 32'h8, IF_ADDR, WALK_BASE + 32'h10};

    done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if_req[k]  = 1'b0;
        ma_req[k]  = (ma_left[k] > 0);
        if_av[k]   = (if_left[k] > 0) && !if_busy[k];
        ma_av[k]   = (ma_left[k] > 0) && !ma_busy[k];
        ma_addr[k] = WALK_BASE + 32'(8 * (3 - ma_left[k]));
        m_ar[k]    = 1'b1;
        m_dv[k]    = pend[k];
        if_dr[k]   = 1'b1;
        ma_dr[k]   = 1'b1;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (m_av[k] && m_ar[k]) begin
          if (nbeat[k] < 8) begin
            beat_ma[k][nbeat[k]]   = g_ma[k];
            beat_addr[k][nbeat[k]] = m_addr[k];
          end
          $display("[TB] walk dut%0d beat %0d side=%s addr=%h", k, nbeat[k],
                   g_ma[k] ? "MA" : "IF", m_addr[k]);
          nbeat[k]++;
          if (g_ma[k]) ma_busy[k] = 1'b1; else if_busy[k] = 1'b1;
          pend[k] = 1'b1;
        end else if (m_dv[k] && m_dr[k]) begin
          pend[k] = 1'b0;
          if (g_ma[k]) begin ma_busy[k] = 1'b0; ma_left[k]--; end
          else begin if_busy[k] = 1'b0; if_left[k]--; end
        end
      end
      done = (ma_left[0] == 0) && (if_left[0] == 0) && (ma_left[1] == 0) && (if_left[1] == 0);
    end

    check("walk_completed", 64'(done), 64'(1));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("walk%0d_beats", k), 64'(nbeat[k]), 64'(4));
      for (int b = 0; b < 4; b++)
        check($sformatf("walk%0d_beat%0d", k, b), {31'd0, beat_ma[k][b], beat_addr[k][b]},
              {31'd0, exp_ma[k][b], exp_baddr[k][b]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
